// File: rtl/tcp_rx_sink.sv
// TCP receive sink: accepts notifications, requests the payload, consumes meta and data
// beats, and keeps byte/packet/cycle statistics with a byte-target completion flag.
module tcp_rx_sink #(
    parameter int  DATA_WIDTH = 512,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [63:0]           target_bytes,

    input  logic                  s_notif_valid,
    output logic                  s_notif_ready,
    input  logic [87:0]           s_notif_data,

    output logic                  m_read_pkg_valid,
    input  logic                  m_read_pkg_ready,
    output logic [31:0]           m_read_pkg_data,

    input  logic                  s_rx_meta_valid,
    output logic                  s_rx_meta_ready,
    input  logic [15:0]           s_rx_meta_data,

    input  logic                  s_rx_data_valid,
    output logic                  s_rx_data_ready,
    input  logic [DATA_WIDTH-1:0] s_rx_data_data,
    input  logic [KEEP_WIDTH-1:0] s_rx_data_keep,
    input  logic                  s_rx_data_last,

    output logic [63:0]           rx_byte_cnt,
    output logic [31:0]           rx_pkt_cnt,
    output logic [63:0]           rx_cycles,
    output logic                  done,
    output logic                  err_len
);

    typedef enum logic [1:0] {IDLE, REQ, META, DATA} state_t;

    state_t      state_q, state_d;
    logic [15:0] sess_q;
    logic [15:0] len_q;
    logic [31:0] acc_q;
    logic        running_q;

    logic        notif_hs, notif_take, rp_hs, meta_hs, data_hs;
    logic [15:0] notif_sess, notif_len;
    logic        notif_closed;
    logic [31:0] beat_sum;

    // Payload bytes, ip and port are consumed but carry nothing this block needs.
    logic        unused_bits;
    assign unused_bits = ^{s_notif_data[87:81], s_notif_data[79:32], s_rx_data_data};

    function automatic logic [31:0] popcnt(input logic [KEEP_WIDTH-1:0] k);
        logic [31:0] c;
        c = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++)
            c = c + {31'b0, k[i]};
        return c;
    endfunction

    assign notif_sess   = s_notif_data[15:0];
    assign notif_len    = s_notif_data[31:16];
    assign notif_closed = s_notif_data[80];

    assign notif_hs   = s_notif_valid && s_notif_ready;
    assign notif_take = notif_hs && !notif_closed && (notif_len != 16'd0);
    assign rp_hs      = m_read_pkg_valid && m_read_pkg_ready;
    assign meta_hs    = s_rx_meta_valid && s_rx_meta_ready;
    assign data_hs    = s_rx_data_valid && s_rx_data_ready;
    assign beat_sum   = acc_q + popcnt(s_rx_data_keep);

    assign m_read_pkg_data = {len_q, sess_q};

    always_comb begin
        state_d          = state_q;
        s_notif_ready    = 1'b0;
        m_read_pkg_valid = 1'b0;
        s_rx_meta_ready  = 1'b0;
        s_rx_data_ready  = 1'b0;
        case (state_q)
            IDLE: begin
                s_notif_ready = enable;
                if (notif_take)
                    state_d = REQ;
            end
            REQ: begin
                m_read_pkg_valid = 1'b1;
                if (rp_hs)
                    state_d = META;
            end
            META: begin
                s_rx_meta_ready = 1'b1;
                if (meta_hs)
                    state_d = DATA;
            end
            DATA: begin
                s_rx_data_ready = 1'b1;
                if (data_hs && s_rx_data_last)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Handshake outputs stay quiet for the whole time reset is held.
        if (!aresetn) begin
            s_notif_ready    = 1'b0;
            m_read_pkg_valid = 1'b0;
            s_rx_meta_ready  = 1'b0;
            s_rx_data_ready  = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            sess_q      <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            running_q   <= 1'b0;
            rx_byte_cnt <= '0;
            rx_pkt_cnt  <= '0;
            rx_cycles   <= '0;
            done        <= 1'b0;
            err_len     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (notif_take) begin
                sess_q    <= notif_sess;
                len_q     <= notif_len;
                acc_q     <= '0;
                running_q <= 1'b1;
            end
            if (meta_hs && (s_rx_meta_data != sess_q))
                err_len <= 1'b1;
            if (data_hs) begin
                if (s_rx_data_last) begin
                    acc_q       <= '0;
                    rx_byte_cnt <= rx_byte_cnt + {32'b0, beat_sum};
                    rx_pkt_cnt  <= rx_pkt_cnt + 32'd1;
                    if (beat_sum != {16'b0, len_q})
                        err_len <= 1'b1;
                end else begin
                    acc_q <= beat_sum;
                end
            end
            if (running_q && !done)
                rx_cycles <= rx_cycles + 64'd1;
            if ((target_bytes != 64'd0) && (rx_byte_cnt >= target_bytes))
                done <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tcp_rx_sink.sv
// Directed bench for tcp_rx_sink with a read_pkg scoreboard and immediate-assertion checks.
module tb_tcp_rx_sink;

    localparam int DW = 512;
    localparam int KW = DW / 8;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          enable;
    logic [63:0]   target_bytes;
    logic          s_notif_valid;
    logic          s_notif_ready;
    logic [87:0]   s_notif_data;
    logic          m_read_pkg_valid;
    logic          m_read_pkg_ready;
    logic [31:0]   m_read_pkg_data;
    logic          s_rx_meta_valid;
    logic          s_rx_meta_ready;
    logic [15:0]   s_rx_meta_data;
    logic          s_rx_data_valid;
    logic          s_rx_data_ready;
    logic [DW-1:0] s_rx_data_data;
    logic [KW-1:0] s_rx_data_keep;
    logic          s_rx_data_last;
    logic [63:0]   rx_byte_cnt;
    logic [31:0]   rx_pkt_cnt;
    logic [63:0]   rx_cycles;
    logic          done;
    logic          err_len;

    always #5 aclk = ~aclk;

    tcp_rx_sink #(.DATA_WIDTH(DW)) dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .enable           (enable),
        .target_bytes     (target_bytes),
        .s_notif_valid    (s_notif_valid),
        .s_notif_ready    (s_notif_ready),
        .s_notif_data     (s_notif_data),
        .m_read_pkg_valid (m_read_pkg_valid),
        .m_read_pkg_ready (m_read_pkg_ready),
        .m_read_pkg_data  (m_read_pkg_data),
        .s_rx_meta_valid  (s_rx_meta_valid),
        .s_rx_meta_ready  (s_rx_meta_ready),
        .s_rx_meta_data   (s_rx_meta_data),
        .s_rx_data_valid  (s_rx_data_valid),
        .s_rx_data_ready  (s_rx_data_ready),
        .s_rx_data_data   (s_rx_data_data),
        .s_rx_data_keep   (s_rx_data_keep),
        .s_rx_data_last   (s_rx_data_last),
        .rx_byte_cnt      (rx_byte_cnt),
        .rx_pkt_cnt       (rx_pkt_cnt),
        .rx_cycles        (rx_cycles),
        .done             (done),
        .err_len          (err_len)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    int          obs_rd = 0;
    int          hs_cnt = 0;
    logic [63:0] cyc = '0;

    always @(posedge aclk) cyc <= cyc + 64'd1;

    // Observed read_pkg transfers; sampled mid-cycle so they are stable for the next edge.
    always @(negedge aclk) begin
        if (m_read_pkg_valid && m_read_pkg_ready) begin
            obs_q.push_back(m_read_pkg_data);
            hs_cnt <= hs_cnt + 1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=no-handshake expected=handshake", tag);
    endtask

    task automatic send_notif(input logic [15:0] s, input logic [15:0] l, input logic closed,
                              output logic [63:0] c);
        logic hs;
        logic ok;
        ok = 1'b0;
        s_notif_data  = {7'b0, closed, 16'd80, 32'h0a000001, l, s};
        s_notif_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            hs = s_notif_ready;
            @(posedge aclk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        s_notif_valid = 1'b0;
        c = cyc;
        if (!ok)
            timeout("notif");
        else if (!closed && l != 16'd0)
            exp_q.push_back({l, s});
    endtask

    task automatic send_meta(input logic [15:0] s);
        logic hs;
        logic ok;
        ok = 1'b0;
        s_rx_meta_data  = s;
        s_rx_meta_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            hs = s_rx_meta_ready;
            @(posedge aclk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        s_rx_meta_valid = 1'b0;
        if (!ok) timeout("meta");
    endtask

    task automatic send_beat(input logic [KW-1:0] k, input logic last);
        logic hs;
        logic ok;
        ok = 1'b0;
        s_rx_data_data  = {16{$urandom()}};
        s_rx_data_keep  = k;
        s_rx_data_last  = last;
        s_rx_data_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge aclk);
            hs = s_rx_data_ready;
            @(posedge aclk);
            #1;
            if (hs) begin
                ok = 1'b1;
                break;
            end
        end
        s_rx_data_valid = 1'b0;
        s_rx_data_last  = 1'b0;
        if (!ok) timeout("beat");
    endtask

    task automatic sb_check(input string tag);
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_rd < obs_q.size()) begin
                chk(tag, {32'b0, obs_q[obs_rd]}, {32'b0, e});
                obs_rd++;
            end else begin
                timeout(tag);
            end
        end
    endtask

    initial begin
        logic [KW-1:0] full;
        logic [KW-1:0] k4;
        logic [63:0]   c;
        logic [63:0]   c0;
        logic [63:0]   exp_cyc;
        int            h;

        full = '1;
        k4   = '0;
        k4[3:0] = 4'hF;

        aresetn          = 1'b0;
        enable           = 1'b1;
        target_bytes     = '0;
        s_notif_valid    = 1'b0;
        s_notif_data     = '0;
        m_read_pkg_ready = 1'b1;
        s_rx_meta_valid  = 1'b0;
        s_rx_meta_data   = '0;
        s_rx_data_valid  = 1'b0;
        s_rx_data_data   = '0;
        s_rx_data_keep   = '0;
        s_rx_data_last   = 1'b0;

        // Reset state, with enable already high
        tick(2);
        chk("rst_notif_ready", {63'b0, s_notif_ready}, 64'd0);
        chk("rst_rp_valid", {63'b0, m_read_pkg_valid}, 64'd0);
        chk("rst_meta_ready", {63'b0, s_rx_meta_ready}, 64'd0);
        chk("rst_data_ready", {63'b0, s_rx_data_ready}, 64'd0);
        chk("rst_bytes", rx_byte_cnt, 64'd0);
        chk("rst_pkts", {32'b0, rx_pkt_cnt}, 64'd0);
        chk("rst_cycles", rx_cycles, 64'd0);
        chk("rst_done_err", {62'b0, done, err_len}, 64'd0);
        aresetn = 1'b1;
        tick(1);
        chk("idle_notif_ready", {63'b0, s_notif_ready}, 64'd1);

        // Single packet: session 5, 128 bytes in two full beats
        send_notif(16'd5, 16'd128, 1'b0, c);
        send_meta(16'd5);
        send_beat(full, 1'b0);
        send_beat(full, 1'b1);
        chk("p1_bytes", rx_byte_cnt, 64'd128);
        chk("p1_pkts", {32'b0, rx_pkt_cnt}, 64'd1);
        chk("p1_err", {63'b0, err_len}, 64'd0);
        chk("p1_rp_data_lit", {32'b0, obs_q[0]}, 64'h0000_0000_0080_0005);
        chk("p1_back_idle", {62'b0, s_notif_ready, s_rx_data_ready}, 64'd2);
        sb_check("p1_rp_data");

        // Closed and zero-length notifications are dropped
        h = hs_cnt;
        send_notif(16'd3, 16'd64, 1'b1, c);
        tick(3);
        chk("closed_no_rp", 64'(hs_cnt), 64'(h));
        chk("closed_idle", {62'b0, s_notif_ready, m_read_pkg_valid}, 64'd2);
        chk("closed_bytes", rx_byte_cnt, 64'd128);
        chk("closed_pkts", {32'b0, rx_pkt_cnt}, 64'd1);
        send_notif(16'd4, 16'd0, 1'b0, c);
        tick(3);
        chk("zlen_no_rp", 64'(hs_cnt), 64'(h));

        // read_pkg backpressure for 5 cycles, then a packet with a keep=0 beat
        m_read_pkg_ready = 1'b0;
        send_notif(16'd7, 16'd128, 1'b0, c);
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            chk("bp_hold", {31'b0, m_read_pkg_valid, m_read_pkg_data}, {31'b0, 1'b1, 32'h0080_0007});
        end
        @(posedge aclk);
        #1;
        m_read_pkg_ready = 1'b1;
        send_meta(16'd7);
        send_beat(full, 1'b0);
        send_beat('0, 1'b0);
        send_beat(full, 1'b1);
        chk("bp_one_hs", 64'(hs_cnt), 64'(h + 1));
        chk("bp_bytes", rx_byte_cnt, 64'd256);
        chk("bp_pkts", {32'b0, rx_pkt_cnt}, 64'd2);
        chk("bp_err", {63'b0, err_len}, 64'd0);
        sb_check("bp_rp_data");

        // Length mismatch: 100 announced, 68 delivered
        send_notif(16'd9, 16'd100, 1'b0, c);
        send_meta(16'd9);
        send_beat(full, 1'b0);
        send_beat(k4, 1'b1);
        chk("mm_bytes", rx_byte_cnt, 64'd324);
        chk("mm_pkts", {32'b0, rx_pkt_cnt}, 64'd3);
        chk("mm_err", {63'b0, err_len}, 64'd1);
        chk("tgt0_no_done", {63'b0, done}, 64'd0);
        tick(2);
        chk("mm_err_sticky", {63'b0, err_len}, 64'd1);
        sb_check("mm_rp_data");

        // Reset in the middle of DATA, then a clean packet
        send_notif(16'd11, 16'd128, 1'b0, c);
        send_meta(16'd11);
        send_beat(full, 1'b0);
        aresetn = 1'b0;
        tick(1);
        chk("mrst_counts", rx_byte_cnt | {32'b0, rx_pkt_cnt} | rx_cycles, 64'd0);
        chk("mrst_flags", {60'b0, done, err_len, s_rx_data_ready, s_notif_ready}, 64'd0);
        chk("mrst_rp_valid", {63'b0, m_read_pkg_valid}, 64'd0);
        aresetn = 1'b1;
        s_rx_data_keep  = full;
        s_rx_data_last  = 1'b1;
        s_rx_data_valid = 1'b1;
        tick(2);
        chk("mrst_idle", {62'b0, s_notif_ready, s_rx_data_ready}, 64'd2);
        chk("mrst_no_beat", {32'b0, rx_pkt_cnt}, 64'd0);
        s_rx_data_valid = 1'b0;
        s_rx_data_last  = 1'b0;
        send_notif(16'd13, 16'd128, 1'b0, c);
        send_meta(16'd13);
        send_beat(full, 1'b0);
        send_beat(full, 1'b1);
        chk("mrst_bytes", rx_byte_cnt, 64'd128);
        chk("mrst_pkts", {32'b0, rx_pkt_cnt}, 64'd1);
        chk("mrst_err", {63'b0, err_len}, 64'd0);
        sb_check("mrst_rp_data");

        // Completion at 256 bytes over two packets
        aresetn = 1'b0;
        tick(2);
        aresetn = 1'b1;
        target_bytes = 64'd256;
        send_notif(16'd1, 16'd128, 1'b0, c0);
        send_meta(16'd1);
        send_beat(full, 1'b0);
        send_beat(full, 1'b1);
        send_notif(16'd2, 16'd128, 1'b0, c);
        send_meta(16'd2);
        send_beat(full, 1'b0);
        send_beat(full, 1'b1);
        chk("cmp_bytes", rx_byte_cnt, 64'd256);
        chk("cmp_done_early", {63'b0, done}, 64'd0);
        tick(1);
        chk("cmp_done", {63'b0, done}, 64'd1);
        exp_cyc = cyc - c0;
        chk("cmp_cycles", rx_cycles, exp_cyc);
        tick(4);
        chk("cmp_cycles_frozen", rx_cycles, exp_cyc);
        chk("cmp_done_hold", {63'b0, done}, 64'd1);
        chk("cmp_pkts", {32'b0, rx_pkt_cnt}, 64'd2);
        sb_check("cmp_rp_data");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
